// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared constants for the ID-stage branch hazard controller: opcodes (inst[6:2]),
// comparator forward selects and FSM state encodings.
package branch_hazard_ctrl_pkg;

    localparam logic [4:0] OPCODE_Branch = 5'b11000;
    localparam logic [4:0] OPCODE_Jal    = 5'b11011;
    localparam logic [4:0] OPCODE_Jalr   = 5'b11001;
    localparam logic [4:0] OPCODE_Load   = 5'b00000;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_EX_MEM = 2'b01;
    localparam logic [1:0] FWD_MEM_WB = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_dep.sv
// Per-source dependency check: stall cycles still needed before the ID comparator
// can read this source, and where its operand should be forwarded from.
module branch_dep_check
    import branch_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       en,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_regwrite,
    input  logic       id_ex_memread,
    input  logic [4:0] ex_mem_rd,
    input  logic       ex_mem_regwrite,
    input  logic       ex_mem_memread,
    input  logic [4:0] mem_wb_rd,
    input  logic       mem_wb_regwrite,
    output logic [1:0] req,
    output logic [1:0] fwd
);

    logic hit_ex, hit_mem, hit_wb;

    assign hit_ex  = en && id_ex_regwrite  && (id_ex_rd  != 5'd0) && (id_ex_rd  == src);
    assign hit_mem = en && ex_mem_regwrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == src);
    assign hit_wb  = en && mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == src);

    always_comb begin
        req = 2'd0;
        fwd = FWD_RF;
        // Nearest producer decides how long the comparator must wait.
        if (hit_ex)
            req = id_ex_memread ? 2'd2 : 2'd1;
        else if (hit_mem)
            req = ex_mem_memread ? 2'd1 : 2'd0;

        if (hit_mem && !ex_mem_memread)
            fwd = FWD_EX_MEM;
        else if (hit_wb)
            fwd = FWD_MEM_WB;
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch resolution hazard controller: stalls on producer dependencies,
// flushes IF/ID on taken control flow and counts stall/flush cycles.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_OPCODE,
    input  logic [4:0]       IF_ID_RegisterRs1,
    input  logic [4:0]       IF_ID_RegisterRs2,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       EX_MEM_RegisterRd,
    input  logic             EX_MEM_RegWrite,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       MEM_WB_RegisterRd,
    input  logic             MEM_WB_RegWrite,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     state, state_n;
    logic [1:0] rem, rem_n;
    logic       is_br, is_cf, use_rs1, use_rs2;
    logic [1:0] req1, req2, fwd1, fwd2, n;
    logic       stall, flush;

    assign is_br   = (IF_ID_OPCODE == OPCODE_Branch);
    assign is_cf   = is_br || (IF_ID_OPCODE == OPCODE_Jal) || (IF_ID_OPCODE == OPCODE_Jalr);
    assign use_rs1 = is_br || (IF_ID_OPCODE == OPCODE_Jalr);
    assign use_rs2 = is_br;

    branch_dep_check u_dep_rs1 (
        .src(IF_ID_RegisterRs1), .en(use_rs1),
        .id_ex_rd(ID_EX_RegisterRd), .id_ex_regwrite(ID_EX_RegWrite), .id_ex_memread(ID_EX_MemRead),
        .ex_mem_rd(EX_MEM_RegisterRd), .ex_mem_regwrite(EX_MEM_RegWrite), .ex_mem_memread(EX_MEM_MemRead),
        .mem_wb_rd(MEM_WB_RegisterRd), .mem_wb_regwrite(MEM_WB_RegWrite),
        .req(req1), .fwd(fwd1)
    );

    branch_dep_check u_dep_rs2 (
        .src(IF_ID_RegisterRs2), .en(use_rs2),
        .id_ex_rd(ID_EX_RegisterRd), .id_ex_regwrite(ID_EX_RegWrite), .id_ex_memread(ID_EX_MemRead),
        .ex_mem_rd(EX_MEM_RegisterRd), .ex_mem_regwrite(EX_MEM_RegWrite), .ex_mem_memread(EX_MEM_MemRead),
        .mem_wb_rd(MEM_WB_RegisterRd), .mem_wb_regwrite(MEM_WB_RegWrite),
        .req(req2), .fwd(fwd2)
    );

    assign n = max2(req1, req2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            rem   <= 2'd0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
        end
    end

    always_comb begin
        state_n  = state;
        rem_n    = rem;
        stall    = 1'b0;
        flush    = 1'b0;
        forwardA = FWD_RF;
        forwardB = FWD_RF;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (is_cf) begin
                        forwardA = fwd1;
                        forwardB = fwd2;
                        if (n != 2'd0) begin
                            stall = 1'b1;
                            if (n == 2'd2) begin
                                state_n = ST_STALL;
                                rem_n   = 2'd1;
                            end
                        end else if (branch_taken) begin
                            flush   = 1'b1;
                            state_n = ST_FLUSH;
                        end
                    end
                end
                // Dependencies are not re-evaluated: the load is known to need this cycle.
                ST_STALL: begin
                    stall = 1'b1;
                    rem_n = rem - 2'd1;
                    if (rem_n == 2'd0)
                        state_n = ST_RUN;
                end
                ST_FLUSH: state_n = ST_RUN;
                default:  state_n = ST_RUN;
            endcase
        end
    end

    assign pc_write     = !stall;
    assign if_id_write  = !stall;
    assign id_ex_bubble = stall;
    assign if_id_flush  = flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: stall, forward, flush, reset and saturation scenarios.
module tb_branch_hazard_ctrl;
    import branch_hazard_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] op, rs1, rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_rw, ex_mr, mem_rw, mem_mr, wb_rw, taken;
    logic       pc_write, if_id_write, id_ex_bubble, if_id_flush;
    logic [1:0] forwardA, forwardB;
    logic [3:0] stall_cnt, flush_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    branch_hazard_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_OPCODE(op), .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2),
        .ID_EX_RegisterRd(ex_rd), .ID_EX_RegWrite(ex_rw), .ID_EX_MemRead(ex_mr),
        .EX_MEM_RegisterRd(mem_rd), .EX_MEM_RegWrite(mem_rw), .EX_MEM_MemRead(mem_mr),
        .MEM_WB_RegisterRd(wb_rd), .MEM_WB_RegWrite(wb_rw),
        .branch_taken(taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .forwardA(forwardA), .forwardB(forwardB),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic clear_in();
        op = 5'b01100; rs1 = 0; rs2 = 0;
        ex_rd = 0; ex_rw = 0; ex_mr = 0;
        mem_rd = 0; mem_rw = 0; mem_mr = 0;
        wb_rd = 0; wb_rw = 0; taken = 0;
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        op = OPCODE_Branch; rs1 = 5'd5; ex_rd = 5'd5; ex_rw = 1; ex_mr = 1;
        mem_rd = 5'd5; mem_rw = 1; taken = 1;
        tick(); tick();
        total_cnt++; if (pc_write !== 1'b1) $display("FAIL reset_pc_write got %b want 1", pc_write); else pass_cnt++;
        total_cnt++; if (if_id_write !== 1'b1) $display("FAIL reset_if_id_write got %b want 1", if_id_write); else pass_cnt++;
        total_cnt++; if (id_ex_bubble !== 1'b0) $display("FAIL reset_bubble got %b want 0", id_ex_bubble); else pass_cnt++;
        total_cnt++; if (if_id_flush !== 1'b0) $display("FAIL reset_flush got %b want 0", if_id_flush); else pass_cnt++;
        total_cnt++; if (forwardA !== 2'b00) $display("FAIL reset_fwdA got %b want 00", forwardA); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0)
            $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cnt, flush_cnt); else pass_cnt++;
        total_cnt++; if (dut.state !== ST_RUN) $display("FAIL reset_state got %0d want %0d", dut.state, ST_RUN); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_alu_stall();
        do_reset();
        op = OPCODE_Branch; rs1 = 5'd5; rs2 = 5'd9; ex_rd = 5'd5; ex_rw = 1;
        #1;
        total_cnt++; if ({pc_write, if_id_write, id_ex_bubble} !== 3'b001)
            $display("FAIL alu_stall_ctl got %b want 001", {pc_write, if_id_write, id_ex_bubble}); else pass_cnt++;
        tick();
        ex_rd = 0; ex_rw = 0; mem_rd = 5'd5; mem_rw = 1;
        #1;
        total_cnt++; if ({pc_write, id_ex_bubble} !== 2'b10)
            $display("FAIL alu_release_ctl got %b want 10", {pc_write, id_ex_bubble}); else pass_cnt++;
        total_cnt++; if (forwardA !== FWD_EX_MEM) $display("FAIL alu_fwdA got %b want 01", forwardA); else pass_cnt++;
        total_cnt++; if (forwardB !== FWD_RF) $display("FAIL alu_fwdB got %b want 00", forwardB); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 4'd1) $display("FAIL alu_stall_cnt got %0d want 1", stall_cnt); else pass_cnt++;
        tick();
        total_cnt++; if (stall_cnt !== 4'd1 || flush_cnt !== 4'd0)
            $display("FAIL alu_after_cnt got %0d/%0d want 1/0", stall_cnt, flush_cnt); else pass_cnt++;
    endtask

    task automatic test_load_stall();
        do_reset();
        op = OPCODE_Branch; rs1 = 5'd3; rs2 = 5'd7; ex_rd = 5'd7; ex_rw = 1; ex_mr = 1;
        #1;
        total_cnt++; if (id_ex_bubble !== 1'b1 || pc_write !== 1'b0)
            $display("FAIL load_stall1 got bubble=%b pc=%b want 1/0", id_ex_bubble, pc_write); else pass_cnt++;
        tick();
        total_cnt++; if (dut.state !== ST_STALL) $display("FAIL load_state got %0d want %0d", dut.state, ST_STALL); else pass_cnt++;
        // Load now in MEM: the stall continues without re-evaluation.
        ex_rd = 0; ex_rw = 0; ex_mr = 0; mem_rd = 5'd7; mem_rw = 1; mem_mr = 1;
        #1;
        total_cnt++; if (id_ex_bubble !== 1'b1 || if_id_write !== 1'b0)
            $display("FAIL load_stall2 got bubble=%b ifid=%b want 1/0", id_ex_bubble, if_id_write); else pass_cnt++;
        tick();
        mem_rd = 0; mem_rw = 0; mem_mr = 0; wb_rd = 5'd7; wb_rw = 1;
        #1;
        total_cnt++; if (id_ex_bubble !== 1'b0 || pc_write !== 1'b1)
            $display("FAIL load_release got bubble=%b pc=%b want 0/1", id_ex_bubble, pc_write); else pass_cnt++;
        total_cnt++; if (forwardB !== FWD_MEM_WB) $display("FAIL load_fwdB got %b want 10", forwardB); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 4'd2) $display("FAIL load_stall_cnt got %0d want 2", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_x0();
        do_reset();
        op = OPCODE_Branch; rs1 = 0; rs2 = 0;
        ex_rd = 0; ex_rw = 1; ex_mr = 1; mem_rd = 0; mem_rw = 1; wb_rd = 0; wb_rw = 1;
        #1;
        total_cnt++; if (id_ex_bubble !== 1'b0 || pc_write !== 1'b1)
            $display("FAIL x0_nostall got bubble=%b pc=%b want 0/1", id_ex_bubble, pc_write); else pass_cnt++;
        total_cnt++; if ({forwardA, forwardB} !== 4'b0000)
            $display("FAIL x0_fwd got %b want 0000", {forwardA, forwardB}); else pass_cnt++;
        tick();
        total_cnt++; if (stall_cnt !== 4'd0) $display("FAIL x0_stall_cnt got %0d want 0", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_taken_flush();
        do_reset();
        op = OPCODE_Branch; rs1 = 5'd1; rs2 = 5'd2; taken = 1;
        #1;
        total_cnt++; if (if_id_flush !== 1'b1 || pc_write !== 1'b1 || id_ex_bubble !== 1'b0)
            $display("FAIL flush_cycle got flush=%b pc=%b bubble=%b want 1/1/0", if_id_flush, pc_write, id_ex_bubble); else pass_cnt++;
        tick();
        total_cnt++; if (dut.state !== ST_FLUSH) $display("FAIL flush_state got %0d want %0d", dut.state, ST_FLUSH); else pass_cnt++;
        total_cnt++; if (flush_cnt !== 4'd1) $display("FAIL flush_cnt got %0d want 1", flush_cnt); else pass_cnt++;
        // Squashed garbage in ID that would otherwise stall and flush.
        rs1 = 5'd4; ex_rd = 5'd4; ex_rw = 1; ex_mr = 1; mem_rd = 5'd2; mem_rw = 1;
        #1;
        total_cnt++; if ({pc_write, id_ex_bubble, if_id_flush} !== 3'b100)
            $display("FAIL flush_nop_ctl got %b want 100", {pc_write, id_ex_bubble, if_id_flush}); else pass_cnt++;
        total_cnt++; if ({forwardA, forwardB} !== 4'b0000)
            $display("FAIL flush_nop_fwd got %b want 0000", {forwardA, forwardB}); else pass_cnt++;
        tick();
        total_cnt++; if (dut.state !== ST_RUN || flush_cnt !== 4'd1 || stall_cnt !== 4'd0)
            $display("FAIL flush_after got state=%0d f=%0d s=%0d want 0/1/0", dut.state, flush_cnt, stall_cnt); else pass_cnt++;
    endtask

    task automatic test_jal_jalr();
        do_reset();
        // JAL reads no registers: a matching producer must not stall it.
        op = OPCODE_Jal; rs1 = 5'd6; rs2 = 5'd6; ex_rd = 5'd6; ex_rw = 1; ex_mr = 1;
        #1;
        total_cnt++; if (id_ex_bubble !== 1'b0) $display("FAIL jal_nostall got %b want 0", id_ex_bubble); else pass_cnt++;
        tick();
        // JALR depends on rs1 only.
        op = OPCODE_Jalr; rs1 = 5'd8; rs2 = 5'd6;
        #1;
        total_cnt++; if (id_ex_bubble !== 1'b0) $display("FAIL jalr_rs2_ignored got %b want 0", id_ex_bubble); else pass_cnt++;
        rs1 = 5'd6; ex_mr = 0;
        #1;
        total_cnt++; if (id_ex_bubble !== 1'b1) $display("FAIL jalr_rs1_stall got %b want 1", id_ex_bubble); else pass_cnt++;
        // Non-control-flow instruction: no stall, no forwarding.
        op = OPCODE_Load; ex_rd = 0; ex_rw = 0; mem_rd = 5'd6; mem_rw = 1;
        #1;
        total_cnt++; if (id_ex_bubble !== 1'b0 || forwardA !== 2'b00)
            $display("FAIL noncf got bubble=%b fwdA=%b want 0/00", id_ex_bubble, forwardA); else pass_cnt++;
    endtask

    task automatic test_reset_in_stall();
        do_reset();
        op = OPCODE_Branch; rs1 = 5'd9; ex_rd = 5'd9; ex_rw = 1; ex_mr = 1;
        tick();
        total_cnt++; if (dut.state !== ST_STALL) $display("FAIL rststall_enter got %0d want %0d", dut.state, ST_STALL); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0)
            $display("FAIL rststall_forced got pc=%b bubble=%b want 1/0", pc_write, id_ex_bubble); else pass_cnt++;
        tick();
        rst = 1'b0;
        clear_in();
        #1;
        total_cnt++; if (dut.state !== ST_RUN || pc_write !== 1'b1)
            $display("FAIL rststall_run got state=%0d pc=%b want 0/1", dut.state, pc_write); else pass_cnt++;
        total_cnt++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0)
            $display("FAIL rststall_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        op = OPCODE_Branch; rs1 = 5'd10; ex_rd = 5'd10; ex_rw = 1;
        for (int i = 0; i < 14; i++) tick();
        total_cnt++; if (stall_cnt !== 4'hE) $display("FAIL sat_14 got %h want e", stall_cnt); else pass_cnt++;
        tick(); tick();
        total_cnt++; if (stall_cnt !== 4'hF) $display("FAIL sat_16 got %h want f", stall_cnt); else pass_cnt++;
        tick();
        total_cnt++; if (stall_cnt !== 4'hF) $display("FAIL sat_hold got %h want f", stall_cnt); else pass_cnt++;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        test_reset();
        test_alu_stall();
        test_load_stall();
        test_x0();
        test_taken_flush();
        test_jal_jalr();
        test_reset_in_stall();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
